// File: rtl/dbg_monitor.sv
// Bring-up debug monitor: probe snapshot, multiplexed hex seven-segment
// display, and free-running or debounced single-step core clock-enable.
module dbg_monitor #(
  parameter int NPROBE      = 16,
  parameter int PW          = 32,
  parameter int SEL_W       = 4,
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEB_CYCLES  = 500000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NPROBE*PW-1:0] probes_i,
  input  logic [SEL_W-1:0]     ssd_sel_i,
  input  logic                 freeze_i,
  input  logic                 run_mode_i,
  input  logic                 step_btn_i,
  output logic                 core_en_o,
  output logic                 sel_valid_o,
  output logic [PW-1:0]        snap_o,
  output logic [NDIG-1:0]      an_o,
  output logic [6:0]           seg_o,
  output logic                 dp_o
);
  localparam int DW  = 4 * NDIG;
  localparam int RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DBW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [PW-1:0] probe_arr [NPROBE];
  for (genvar k = 0; k < NPROBE; k++) begin : g_probe
    assign probe_arr[k] = probes_i[k*PW +: PW];
  end

  logic [PW-1:0]   snap_q, snap_d, probe_sel;
  logic            sel_valid_q, sel_valid_d, sel_ok;
  logic [RW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NDIG-1:0] an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [3:0]      nib;
  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d, deb_prev_q;
  logic [DBW-1:0]  deb_cnt_q, deb_cnt_d;
  logic            core_en_q, core_en_d;

  always_comb begin
    sel_ok    = int'(ssd_sel_i) < NPROBE;
    probe_sel = '0;
    for (int k = 0; k < NPROBE; k++)
      if (ssd_sel_i == SEL_W'(k)) probe_sel = probe_arr[k];
  end

  assign nib = 4'(DW'(snap_q) >> (4 * idx_q));

  always_comb begin
    snap_d      = snap_q;
    sel_valid_d = sel_valid_q;
    if (!freeze_i) begin
      sel_valid_d = sel_ok;
      snap_d      = sel_ok ? probe_sel : '0;
    end

    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == RW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end
    an_d  = ~(NDIG'(1) << idx_q);
    seg_d = sel_valid_q ? hex7(nib) : 7'b0111111;
    dp_d  = ~((idx_q == '0) & freeze_i);

    // Level only moves after DEB_CYCLES consecutive disagreeing samples.
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DBW'(DEB_CYCLES - 1)) deb_d = sync2_q;
      else                                   deb_cnt_d = deb_cnt_q + 1'b1;
    end
    core_en_d = run_mode_i | (deb_q & ~deb_prev_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      snap_q      <= '0;
      sel_valid_q <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      an_q        <= '1;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_q       <= 1'b0;
      deb_prev_q  <= 1'b0;
      deb_cnt_q   <= '0;
      core_en_q   <= 1'b0;
    end else begin
      snap_q      <= snap_d;
      sel_valid_q <= sel_valid_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      sync1_q     <= step_btn_i;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      deb_cnt_q   <= deb_cnt_d;
      core_en_q   <= core_en_d;
    end
  end

  assign snap_o      = snap_q;
  assign sel_valid_o = sel_valid_q;
  assign an_o        = an_q;
  assign seg_o       = seg_q;
  assign dp_o        = dp_q;
  assign core_en_o   = core_en_q;
endmodule

// File: tb/tb_dbg_monitor.sv
// Randomized scoreboard bench for dbg_monitor: a window-based reference model
// predicts every output each cycle; a negedge monitor pops and compares.
module tb_dbg_monitor;
  localparam int NP = 12, PW = 32, SW = 4, ND = 4, RD = 4, DEB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b0;
  logic [NP*PW-1:0] probes = '0;
  logic [SW-1:0]    sel = '0;
  logic             freeze = 1'b0, run_mode = 1'b0, btn = 1'b0;
  logic             core_en, sel_valid, dp;
  logic [PW-1:0]    snap;
  logic [ND-1:0]    an;
  logic [6:0]       seg;

  dbg_monitor #(.NPROBE(NP), .PW(PW), .SEL_W(SW), .NDIG(ND),
                .REFRESH_DIV(RD), .DEB_CYCLES(DEB)) dut (
    .clk_i(clk), .rst_i(rst), .probes_i(probes), .ssd_sel_i(sel),
    .freeze_i(freeze), .run_mode_i(run_mode), .step_btn_i(btn),
    .core_en_o(core_en), .sel_valid_o(sel_valid), .snap_o(snap),
    .an_o(an), .seg_o(seg), .dp_o(dp));

  typedef struct {
    logic          core_en, sel_valid, dp;
    logic [PW-1:0] snap;
    logic [ND-1:0] an;
    logic [6:0]    seg;
  } exp_t;

  exp_t q[$];
  int   nchk = 0, npass = 0;

  logic [6:0] HEX [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model state: edges since reset, snapshot, raw button history.
  int            m_n = 0;
  logic [PW-1:0] m_snap = '0;
  logic          m_valid = 1'b0, m_deb = 1'b0, m_rose = 1'b0;
  bit            m_hist[$];

  function automatic void hist_clear();
    m_hist.delete();
    for (int i = 0; i < DEB + 2; i++) m_hist.push_back(1'b0);
  endfunction

  function automatic void model_step();
    exp_t          e;
    logic [PW-1:0] old_snap;
    logic          old_valid, flip;
    int            d, s;
    if (!rst) begin
      m_n = 0; m_snap = '0; m_valid = 0; m_deb = 0; m_rose = 0;
      hist_clear();
      e.core_en = 0; e.sel_valid = 0; e.snap = '0;
      e.an = '1; e.seg = 7'h7F; e.dp = 1;
    end else begin
      m_n++;
      old_snap = m_snap; old_valid = m_valid;
      if (!freeze) begin
        s = int'(sel);
        m_valid = (s < NP);
        m_snap  = m_valid ? probes[s*PW +: PW] : '0;
      end
      d      = ((m_n - 1) / RD) % ND;
      e.an   = ~(ND'(1) << d);
      e.seg  = old_valid ? HEX[(old_snap >> (4*d)) & 32'hF] : 7'b0111111;
      e.dp   = !(d == 0 && freeze);
      // The synchroniser delays the button by two edges; accept a new
      // level once the last DEB delayed samples all disagree with it.
      flip = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (m_hist[m_hist.size() - 2 - j] == m_deb) flip = 1'b0;
      e.core_en = run_mode | m_rose;
      m_rose    = flip && !m_deb;
      if (flip) m_deb = !m_deb;
      m_hist.push_back(btn);
      void'(m_hist.pop_front());
      e.snap = m_snap; e.sel_valid = m_valid;
    end
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("core_en",   32'(core_en),   32'(e.core_en));
      chk("sel_valid", 32'(sel_valid), 32'(e.sel_valid));
      chk("snap",      snap,           e.snap);
      chk("an",        32'(an),        32'(e.an));
      chk("seg",       32'(seg),       32'(e.seg));
      chk("dp",        32'(dp),        32'(e.dp));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_cnt(input int n, output int pulses, output int first);
    pulses = 0; first = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (core_en) begin
        pulses++;
        if (first < 0) first = i + 1;
      end
    end
  endtask

  task automatic set_probe(input int k, input logic [PW-1:0] v);
    probes[k*PW +: PW] = v;
  endtask

  initial begin
    int p, f, p2, f2, hold;
    hist_clear();
    // Reset and first digit
    repeat (3) tick();
    chk("rst_core_en", 32'(core_en), 0);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_snap", snap, 0);
    rst = 1'b1;
    tick();
    chk("first_an", 32'(an), 32'b1110);
    tick();
    chk("first_seg", 32'(seg), 32'b1000000);

    // Sampling and full scan of 1A3F
    set_probe(5, 32'h0000_1A3F); sel = 4'd5;
    tick();
    chk("sample", snap, 32'h1A3F);
    repeat (20) tick();

    // Freeze holds the snapshot
    freeze = 1'b1; set_probe(5, 32'h2222);
    repeat (20) tick();
    chk("frozen", snap, 32'h1A3F);
    freeze = 1'b0;
    tick();
    chk("unfrozen", snap, 32'h2222);

    // Out-of-range select shows dashes
    sel = 4'd13;
    tick();
    chk("oor_valid", 32'(sel_valid), 0);
    chk("oor_snap", snap, 0);
    repeat (20) tick();
    sel = 4'd5;

    // Debounce: bounce, hold, release, press again
    run_mode = 1'b0;
    p2 = 0;
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      run_cnt(3, p, f);
      p2 += p;
    end
    btn = 1'b0;
    run_cnt(6, p, f);
    chk("bounce_pulses", 32'(p2 + p), 0);
    btn = 1'b1;
    run_cnt(20, p, f);
    chk("hold_pulses", 32'(p), 1);
    chk("hold_latency", 32'(f), 11);
    btn = 1'b0;
    run_cnt(20, p, f);
    chk("release_pulses", 32'(p), 0);
    btn = 1'b1;
    run_cnt(20, p, f);
    chk("press2_pulses", 32'(p), 1);
    btn = 1'b0;
    run_cnt(20, p, f);

    // Run mode
    run_mode = 1'b1;
    run_cnt(10, p, f);
    chk("run_cycles", 32'(p), 10);
    run_mode = 1'b0;
    tick();
    chk("run_drop", 32'(core_en), 0);

    // Reset mid-debounce
    btn = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("rst_mid_core_en", 32'(core_en), 0);
    rst = 1'b1; btn = 1'b0;
    run_cnt(20, p, f);
    chk("post_rst_pulses", 32'(p), 0);
    btn = 1'b1;
    run_cnt(20, p, f);
    chk("rehold_pulses", 32'(p), 1);
    btn = 1'b0;
    repeat (12) tick();

    // Randomized phase
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) sel = SW'($urandom_range(0, 15));
      set_probe($urandom_range(0, NP - 1), $urandom);
      if ($urandom_range(0, 9) == 0) freeze = ~freeze;
      if ($urandom_range(0, 39) == 0) run_mode = ~run_mode;
      if (hold == 0) begin
        btn  = ~btn;
        hold = $urandom_range(1, 14);
      end else hold--;
      rst = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
